// File: rtl/uart_flash_manager.sv
// Command-frame bridge between the UART byte interface and the flash controller.
// Optional frame timeout enabled by defining UART_FLASH_MANAGER_TIMEOUT_EN.
module uart_flash_manager #(
    parameter int         ADDR_BYTES = 1,
    parameter logic [7:0] ACK_BYTE   = 8'h06,
    parameter logic [7:0] NAK_BYTE   = 8'h15
`ifdef UART_FLASH_MANAGER_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYC = 50_000_000
`endif
) (
    input  logic                    CLK_50MHZ,
    input  logic                    RST,
    input  logic [7:0]              RS_DATAOUT,
    input  logic                    RS_DONE,
    output logic [7:0]              RS_DATAIN,
    output logic                    RS_TRG_WRITE,
    input  logic                    RS_TX_BUSY,
    output logic [8*ADDR_BYTES-1:0] FL_ADDR,
    output logic [7:0]              FL_DOUT,
    input  logic [7:0]              FL_DIN,
    output logic                    FL_WE,
    output logic                    FL_TRG,
    input  logic                    FL_STATUS,
    output logic                    BUSY,
    output logic                    ERR
);
    localparam int              AW       = 8 * ADDR_BYTES;
    localparam logic [AW-1:0]   ADDR_ONE = 1;
    localparam logic [1:0]      ALAST    = 2'(ADDR_BYTES - 1);
    localparam logic [7:0]      CMD_W    = 8'h57;
    localparam logic [7:0]      CMD_R    = 8'h52;

    typedef enum logic [3:0] {
        IDLE, ADDR, LEN, WDATA, FL_ISSUE, FL_WAIT, TX_ISSUE, TX_WAIT, RESP
    } state_t;

    state_t         state;
    logic           wr_mode;
    logic           resp_mode;
    logic           wphase;
    logic           hold_vld;
    logic [7:0]     hold_byte;
    logic [1:0]     abyte;
    logic [8:0]     cnt;
    logic [1:0]     skip;
    logic [7:0]     tx_byte;
    logic [AW+7:0]  addr_sh;
    logic           wdone;
    logic           consume;
    logic           tmo_hit;

    assign addr_sh = {FL_ADDR, RS_DATAOUT};
    assign wdone   = RS_DONE && wphase;
    assign consume = (state == WDATA) && hold_vld;
    assign BUSY    = (state != IDLE);

`ifdef UART_FLASH_MANAGER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        rx_state;
    assign rx_state = (state == ADDR) || (state == LEN) || (state == WDATA);
    assign tmo_hit  = rx_state && !RS_DONE && (tmo_cnt == 32'(TIMEOUT_CYC - 1));

    // Counter is frozen during flash ops so it measures host silence only.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST || RS_DONE || state == IDLE)
            tmo_cnt <= '0;
        else if (rx_state)
            tmo_cnt <= tmo_cnt + 32'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state        <= IDLE;
            wr_mode      <= 1'b0;
            resp_mode    <= 1'b0;
            wphase       <= 1'b0;
            hold_vld     <= 1'b0;
            hold_byte    <= '0;
            abyte        <= '0;
            cnt          <= '0;
            skip         <= '0;
            tx_byte      <= '0;
            RS_DATAIN    <= '0;
            RS_TRG_WRITE <= 1'b0;
            FL_ADDR      <= '0;
            FL_DOUT      <= '0;
            FL_WE        <= 1'b0;
            FL_TRG       <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            // Holding register accepts a byte if empty or being drained this cycle.
            if (wdone) begin
                if (hold_vld && !consume) begin
                    ERR <= 1'b1;
                end else begin
                    hold_vld  <= 1'b1;
                    hold_byte <= RS_DATAOUT;
                end
            end else if (consume) begin
                hold_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (RS_DONE) begin
                        if (RS_DATAOUT == CMD_W || RS_DATAOUT == CMD_R) begin
                            wr_mode <= (RS_DATAOUT == CMD_W);
                            abyte   <= '0;
                            state   <= ADDR;
                        end else begin
                            tx_byte <= NAK_BYTE;
                            state   <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (RS_DONE) begin
                        FL_ADDR <= addr_sh[AW-1:0];
                        abyte   <= abyte + 2'd1;
                        if (abyte == ALAST)
                            state <= LEN;
                    end else if (tmo_hit) begin
                        tx_byte <= NAK_BYTE;
                        state   <= RESP;
                    end
                end
                LEN: begin
                    if (RS_DONE) begin
                        cnt <= (RS_DATAOUT == 8'd0) ? 9'd256 : {1'b0, RS_DATAOUT};
                        if (wr_mode) begin
                            wphase <= 1'b1;
                            state  <= WDATA;
                        end else begin
                            state  <= FL_ISSUE;
                        end
                    end else if (tmo_hit) begin
                        tx_byte <= NAK_BYTE;
                        state   <= RESP;
                    end
                end
                WDATA: begin
                    if (hold_vld) begin
                        FL_DOUT <= hold_byte;
                        state   <= FL_ISSUE;
                    end else if (tmo_hit) begin
                        wphase   <= 1'b0;
                        hold_vld <= 1'b0;
                        tx_byte  <= NAK_BYTE;
                        state    <= RESP;
                    end
                end
                FL_ISSUE: begin
                    FL_TRG <= 1'b1;
                    FL_WE  <= wr_mode;
                    skip   <= '0;
                    state  <= FL_WAIT;
                end
                FL_WAIT: begin
                    FL_TRG <= 1'b0;
                    // Strobe cycle and the one after it cannot show flash busy yet.
                    if (skip != 2'd2) begin
                        skip <= skip + 2'd1;
                    end else if (!FL_STATUS) begin
                        FL_WE   <= 1'b0;
                        FL_ADDR <= FL_ADDR + ADDR_ONE;
                        cnt     <= cnt - 9'd1;
                        if (wr_mode) begin
                            if (cnt == 9'd1) begin
                                wphase   <= 1'b0;
                                hold_vld <= 1'b0;
                                tx_byte  <= ACK_BYTE;
                                state    <= RESP;
                            end else begin
                                state <= WDATA;
                            end
                        end else begin
                            tx_byte <= FL_DIN;
                            state   <= TX_ISSUE;
                        end
                    end
                end
                TX_ISSUE: begin
                    if (!RS_TX_BUSY) begin
                        RS_DATAIN    <= tx_byte;
                        RS_TRG_WRITE <= 1'b1;
                        skip         <= '0;
                        state        <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    RS_TRG_WRITE <= 1'b0;
                    if (skip != 2'd2) begin
                        skip <= skip + 2'd1;
                    end else if (!RS_TX_BUSY) begin
                        if (resp_mode) begin
                            resp_mode <= 1'b0;
                            state     <= IDLE;
                        end else if (cnt != 9'd0) begin
                            state <= FL_ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RESP: begin
                    resp_mode <= 1'b1;
                    state     <= TX_ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
